// File: rtl/calc_mp_engine.sv
// calc_mp_engine: multi-port calculator. Each requester port captures a
// two-cycle request (op1 then op2) into its own FIFO. A round-robin arbiter
// issues one queued request per cycle to a shared registered ALU. The result
// returns on the originating port for exactly one cycle, with the request tag.
module calc_mp_engine #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [4*NUM_PORTS-1:0]        req_cmd_in,
  input  logic [DATA_W*NUM_PORTS-1:0]   req_data_in,
  input  logic [TAG_W*NUM_PORTS-1:0]    req_tag_in,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [2*NUM_PORTS-1:0]        out_resp,
  output logic [DATA_W*NUM_PORTS-1:0]   out_data,
  output logic [TAG_W*NUM_PORTS-1:0]    out_tag
);

  localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = AW + 1;
  localparam int SH_W    = $clog2(DATA_W);
  localparam int ENTRY_W = 4 + 2 * DATA_W + TAG_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_OP2 = 1'b1} cap_state_t;

  // Capture FSM state and the op1-cycle holding registers
  cap_state_t          state_r    [NUM_PORTS];
  cap_state_t          state_nx_s [NUM_PORTS];
  logic [3:0]          cmd_hold_r [NUM_PORTS];
  logic [DATA_W-1:0]   op1_hold_r [NUM_PORTS];
  logic [TAG_W-1:0]    tag_hold_r [NUM_PORTS];
  logic [NUM_PORTS-1:0] accept_s;
  logic [NUM_PORTS-1:0] push_s;
  logic [NUM_PORTS-1:0] pop_s;
  logic [NUM_PORTS-1:0] nonempty_s;

  // Per-port request FIFOs, entry = {cmd, op1, op2, tag}
  logic [ENTRY_W-1:0]  fifo_mem_r [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r   [NUM_PORTS];
  logic [AW-1:0]       rd_ptr_r   [NUM_PORTS];
  logic [CNT_W-1:0]    count_r    [NUM_PORTS];

  // Arbiter and ALU stage
  logic [PTR_W-1:0]    arb_ptr_r;
  logic                grant_valid_s;
  logic [PTR_W-1:0]    grant_idx_s;
  logic                stage_valid_r;
  logic [PTR_W-1:0]    stage_port_r;
  logic [ENTRY_W-1:0]  stage_entry_r;
  logic [3:0]          stage_cmd_s;
  logic [DATA_W-1:0]   stage_op1_s;
  logic [DATA_W-1:0]   stage_op2_s;
  logic [TAG_W-1:0]    stage_tag_s;
  logic [DATA_W:0]     sum_s;
  logic [1:0]          alu_resp_s;
  logic [DATA_W-1:0]   alu_data_s;

  // Port index base+off, wrapped modulo NUM_PORTS (off < NUM_PORTS)
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) begin
      s = s - NUM_PORTS;
    end else begin
      s = s;
    end
    return PTR_W'(s);
  endfunction

  // Ready reserves a FIFO slot for a request whose op2 is still to come
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      req_ready[p]  = ((count_r[p] + CNT_W'(state_r[p] == ST_OP2)) < DEPTH_C);
      nonempty_s[p] = (count_r[p] != CNT_W'(0));
    end
  end

  // Capture FSM next state: IDLE takes op1 when ready, OP2 takes op2 and pushes
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_nx_s[p] = state_r[p];
      accept_s[p]   = 1'b0;
      push_s[p]     = 1'b0;
      case (state_r[p])
        ST_IDLE: begin
          if ((req_cmd_in[4*p +: 4] != 4'h0) && req_ready[p]) begin
            accept_s[p]   = 1'b1;
            state_nx_s[p] = ST_OP2;
          end else begin
            state_nx_s[p] = ST_IDLE;
          end
        end
        ST_OP2: begin
          push_s[p]     = 1'b1;
          state_nx_s[p] = ST_IDLE;
        end
        default: begin
          state_nx_s[p] = ST_IDLE;
        end
      endcase
    end
  end

  // Capture FSM state register and op1-cycle holding registers
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_r[p]    <= ST_IDLE;
        cmd_hold_r[p] <= 4'h0;
        op1_hold_r[p] <= '0;
        tag_hold_r[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_r[p] <= state_nx_s[p];
        if (accept_s[p]) begin
          cmd_hold_r[p] <= req_cmd_in[4*p +: 4];
          op1_hold_r[p] <= req_data_in[DATA_W*p +: DATA_W];
          tag_hold_r[p] <= req_tag_in[TAG_W*p +: TAG_W];
        end
      end
    end
  end

  // FIFO storage write; contents are meaningless while the count is zero
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push_s[p]) begin
        fifo_mem_r[p][wr_ptr_r[p]] <= {cmd_hold_r[p], op1_hold_r[p],
                                       req_data_in[DATA_W*p +: DATA_W], tag_hold_r[p]};
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_r[p] <= '0;
        rd_ptr_r[p] <= '0;
        count_r[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push_s[p]) begin
          wr_ptr_r[p] <= wr_ptr_r[p] + AW'(1);
        end
        if (pop_s[p]) begin
          rd_ptr_r[p] <= rd_ptr_r[p] + AW'(1);
        end
        case ({push_s[p], pop_s[p]})
          2'b10:   count_r[p] <= count_r[p] + CNT_W'(1);
          2'b01:   count_r[p] <= count_r[p] - CNT_W'(1);
          default: count_r[p] <= count_r[p];
        endcase
      end
    end
  end

  // Round-robin grant: first non-empty FIFO at or after the pointer
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    pop_s         = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_valid_s && nonempty_s[wrap_add(arb_ptr_r, i)]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = wrap_add(arb_ptr_r, i);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
    if (grant_valid_s) begin
      pop_s[grant_idx_s] = 1'b1;
    end else begin
      pop_s = '0;
    end
  end

  // Arbiter pointer and ALU input stage
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      arb_ptr_r     <= '0;
      stage_valid_r <= 1'b0;
      stage_port_r  <= '0;
      stage_entry_r <= '0;
    end else begin
      stage_valid_r <= grant_valid_s;
      if (grant_valid_s) begin
        arb_ptr_r     <= wrap_add(grant_idx_s, 1);
        stage_port_r  <= grant_idx_s;
        stage_entry_r <= fifo_mem_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
      end
    end
  end

  assign stage_cmd_s = stage_entry_r[ENTRY_W-1 -: 4];
  assign stage_op1_s = stage_entry_r[TAG_W+2*DATA_W-1 -: DATA_W];
  assign stage_op2_s = stage_entry_r[TAG_W+DATA_W-1 -: DATA_W];
  assign stage_tag_s = stage_entry_r[TAG_W-1:0];

  // ALU: add/sub flag overflow/underflow as error, shifts use low log2(DATA_W) bits
  always_comb begin
    alu_resp_s = 2'd0;
    alu_data_s = '0;
    sum_s      = {1'b0, stage_op1_s} + {1'b0, stage_op2_s};
    case (stage_cmd_s)
      4'd1: begin
        if (sum_s[DATA_W]) begin
          alu_resp_s = 2'd2;
          alu_data_s = '0;
        end else begin
          alu_resp_s = 2'd1;
          alu_data_s = sum_s[DATA_W-1:0];
        end
      end
      4'd2: begin
        if (stage_op2_s > stage_op1_s) begin
          alu_resp_s = 2'd2;
          alu_data_s = '0;
        end else begin
          alu_resp_s = 2'd1;
          alu_data_s = stage_op1_s - stage_op2_s;
        end
      end
      4'd5: begin
        alu_resp_s = 2'd1;
        alu_data_s = stage_op1_s << stage_op2_s[SH_W-1:0];
      end
      4'd6: begin
        alu_resp_s = 2'd1;
        alu_data_s = stage_op1_s >> stage_op2_s[SH_W-1:0];
      end
      default: begin
        alu_resp_s = 2'd2;
        alu_data_s = '0;
      end
    endcase
  end

  // Registered response: only the granted port shows a non-zero result
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (stage_valid_r && (stage_port_r == PTR_W'(p))) begin
          out_resp[2*p +: 2]           <= alu_resp_s;
          out_data[DATA_W*p +: DATA_W] <= alu_data_s;
          out_tag[TAG_W*p +: TAG_W]    <= stage_tag_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_mp_engine.sv
// Directed testbench for calc_mp_engine: a default 4-port/32-bit build and a
// 2-port/16-bit/depth-2 build, sharing clock and reset.
module tb_calc_mp_engine;

  logic         c_clk;
  logic         reset;
  logic [15:0]  req_cmd_in;
  logic [127:0] req_data_in;
  logic [7:0]   req_tag_in;
  logic [3:0]   req_ready;
  logic [7:0]   out_resp;
  logic [127:0] out_data;
  logic [7:0]   out_tag;

  logic [7:0]   p2_cmd;
  logic [31:0]  p2_data;
  logic [3:0]   p2_tag;
  logic [1:0]   p2_ready;
  logic [3:0]   p2_resp;
  logic [31:0]  p2_out_data;
  logic [3:0]   p2_out_tag;

  int check_cnt;
  int pass_cnt;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] data;
    logic [1:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  calc_mp_engine dut (
    .c_clk(c_clk), .reset(reset),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready(req_ready), .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag)
  );

  calc_mp_engine #(.NUM_PORTS(2), .DATA_W(16), .TAG_W(2), .FIFO_DEPTH(2)) dut2 (
    .c_clk(c_clk), .reset(reset),
    .req_cmd_in(p2_cmd), .req_data_in(p2_data), .req_tag_in(p2_tag),
    .req_ready(p2_ready), .out_resp(p2_resp), .out_data(p2_out_data), .out_tag(p2_out_tag)
  );

  // Clock generation
  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic clear_all();
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
    p2_cmd      = '0;
    p2_data     = '0;
    p2_tag      = '0;
  endtask

  task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
    req_cmd_in[4*p +: 4]   = c;
    req_data_in[32*p +: 32] = d;
    req_tag_in[2*p +: 2]   = t;
  endtask

  task automatic apply_reset();
    clear_all();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // One request on port p; result must appear exactly 2 cycles after op2, one cycle wide
  task automatic run_single(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                            input logic [31:0] op2, input logic [1:0] tag,
                            input logic [1:0] exp_resp, input logic [31:0] exp_data,
                            input string name);
    logic [7:0]   er;
    logic [127:0] ed;
    logic [7:0]   et;
    er = '0; ed = '0; et = '0;
    er[2*p +: 2]   = exp_resp;
    ed[32*p +: 32] = exp_data;
    et[2*p +: 2]   = tag;
    check_cnt++;
    if (req_ready[p] !== 1'b1) $display("FAIL %s_ready: req_ready=%b, required bit %0d set", name, req_ready, p);
    else pass_cnt++;
    set_port(p, cmd, op1, tag);
    step();
    set_port(p, 4'hF, op2, 2'h3);   // cmd/tag in the op2 cycle must be ignored
    step();
    clear_all();
    step();
    check_cnt++;
    if (out_resp !== 8'h00) $display("FAIL %s_early: out_resp=%h, required 00", name, out_resp);
    else pass_cnt++;
    step();
    check_cnt++;
    if (out_resp !== er || out_data !== ed || out_tag !== et)
      $display("FAIL %s: resp=%h data=%h tag=%h, required resp=%h data=%h tag=%h",
               name, out_resp, out_data, out_tag, er, ed, et);
    else pass_cnt++;
    step();
    check_cnt++;
    if (out_resp !== 8'h00 || out_data !== 128'h0 || out_tag !== 8'h00)
      $display("FAIL %s_width: resp=%h data=%h tag=%h, required all zero", name, out_resp, out_data, out_tag);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    clear_all();
    reset = 1'b0;
    step();
    step();
    check_cnt++;
    if (out_resp !== 8'h00 || out_data !== 128'h0 || out_tag !== 8'h00)
      $display("FAIL reset_outputs: resp=%h data=%h tag=%h, required all zero", out_resp, out_data, out_tag);
    else pass_cnt++;
    reset = 1'b1;
    step();
    check_cnt++;
    if (req_ready !== 4'hF) $display("FAIL reset_ready: req_ready=%b, required 1111", req_ready);
    else pass_cnt++;
    check_cnt++;
    if (p2_ready !== 2'b11 || p2_resp !== 4'h0) $display("FAIL reset_p2: ready=%b resp=%h, required 11 / 0", p2_ready, p2_resp);
    else pass_cnt++;
  endtask

  task automatic test_single_add();
    run_single(0, 4'd1, 32'h30, 32'h20, 2'd1, 2'd1, 32'h50, "single_add");
  endtask

  task automatic test_errors();
    run_single(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 2'd2, 32'h0, "add_carry");
    run_single(1, 4'd1, 32'hFFFF_FFFE, 32'h1, 2'd0, 2'd1, 32'hFFFF_FFFF, "add_max");
    run_single(0, 4'd2, 32'h5, 32'h6, 2'd3, 2'd2, 32'h0, "sub_under");
    run_single(3, 4'd2, 32'h6, 32'h6, 2'd1, 2'd1, 32'h0, "sub_equal");
    run_single(2, 4'd3, 32'h5, 32'h6, 2'd2, 2'd2, 32'h0, "bad_cmd");
    run_single(0, 4'd5, 32'h1, 32'h24, 2'd1, 2'd1, 32'h10, "shl");
    run_single(1, 4'd6, 32'h8000_0000, 32'd31, 2'd0, 2'd1, 32'h1, "shr");
  endtask

  task automatic test_back_to_back();
    set_port(1, 4'd2, 32'h100, 2'd1);
    step();
    set_port(1, 4'd0, 32'h1, 2'd0);
    step();
    set_port(1, 4'd5, 32'h3, 2'd1);
    step();
    set_port(1, 4'd0, 32'h2, 2'd0);
    step();
    clear_all();
    check_cnt++;
    if (out_resp !== 8'h04 || out_data !== {64'h0, 32'hFF, 32'h0} || out_tag !== 8'h04)
      $display("FAIL b2b_first: resp=%h data=%h tag=%h, required resp=04 data[63:32]=ff tag=04", out_resp, out_data, out_tag);
    else pass_cnt++;
    step();
    check_cnt++;
    if (out_resp !== 8'h00) $display("FAIL b2b_gap: resp=%h, required 00", out_resp);
    else pass_cnt++;
    step();
    check_cnt++;
    if (out_resp !== 8'h04 || out_data !== {64'h0, 32'hC, 32'h0} || out_tag !== 8'h04)
      $display("FAIL b2b_second: resp=%h data=%h tag=%h, required resp=04 data[63:32]=c tag=04", out_resp, out_data, out_tag);
    else pass_cnt++;
    step();
  endtask

  task automatic test_arbitration();
    logic [7:0]   er;
    logic [127:0] ed;
    logic [7:0]   et;
    apply_reset();
    for (int p = 0; p < 4; p++) set_port(p, 4'd1, 32'(p), 2'(p));
    step();
    for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'h1, 2'd0);
    step();
    clear_all();
    step();
    for (int p = 0; p < 4; p++) begin
      step();
      er = '0; ed = '0; et = '0;
      er[2*p +: 2]   = 2'd1;
      ed[32*p +: 32] = 32'(p + 1);
      et[2*p +: 2]   = 2'(p);
      check_cnt++;
      if (out_resp !== er || out_data !== ed || out_tag !== et)
        $display("FAIL arb_port%0d: resp=%h data=%h tag=%h, required resp=%h data=%h tag=%h",
                 p, out_resp, out_data, out_tag, er, ed, et);
      else pass_cnt++;
    end
    step();
    check_cnt++;
    if (out_resp !== 8'h00) $display("FAIL arb_done: resp=%h, required 00", out_resp);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int          phase[4];
    int          nreq[4];
    logic [31:0] pend_op1[4];
    logic [31:0] pend_op2[4];
    logic [1:0]  pend_tag[4];
    logic [1:0]  r;
    int          idx;
    int          nresp;
    bit          multi;
    bit          dropped;
    multi = 1'b0;
    dropped = 1'b0;
    exp_q.delete();
    for (int p = 0; p < 4; p++) begin
      phase[p] = 0;
      nreq[p]  = 0;
    end
    for (int cyc = 0; cyc < 80; cyc++) begin
      nresp = 0;
      for (int p = 0; p < 4; p++) begin
        r = out_resp[2*p +: 2];
        if (r != 2'd0) begin
          nresp++;
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k].port == 2'(p)) idx = k;
          check_cnt++;
          if (idx < 0) begin
            $display("FAIL bp_unexpected port %0d: resp=%0d data=%h, required no response", p, r, out_data[32*p +: 32]);
          end else if (r !== 2'd1 || out_data[32*p +: 32] !== exp_q[idx].data || out_tag[2*p +: 2] !== exp_q[idx].tag) begin
            $display("FAIL bp_resp port %0d: resp=%0d data=%h tag=%0d, required resp=1 data=%h tag=%0d",
                     p, r, out_data[32*p +: 32], out_tag[2*p +: 2], exp_q[idx].data, exp_q[idx].tag);
            exp_q.delete(idx);
          end else begin
            pass_cnt++;
            exp_q.delete(idx);
          end
        end
      end
      if (nresp > 1) multi = 1'b1;
      for (int p = 0; p < 4; p++) begin
        if (phase[p] == 1) begin
          set_port(p, 4'd1, pend_op2[p], 2'd0);
          exp_q.push_back('{port: 2'(p), data: pend_op1[p] + pend_op2[p], tag: pend_tag[p]});
          phase[p] = 0;
        end else if (cyc < 20) begin
          pend_op1[p] = 32'(p * 4096 + nreq[p] * 16);
          pend_op2[p] = 32'(nreq[p] + 1);
          pend_tag[p] = 2'(nreq[p]);
          set_port(p, 4'd1, pend_op1[p], pend_tag[p]);
          if (req_ready[p]) begin
            phase[p] = 1;
            nreq[p]++;
          end else begin
            dropped = 1'b1;
          end
        end else begin
          set_port(p, 4'd0, 32'h0, 2'd0);
        end
      end
      step();
    end
    check_cnt++;
    if (dropped !== 1'b1) $display("FAIL bp_ready_drop: no port saw req_ready=0, required at least one");
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL bp_missing: %0d responses outstanding, required 0", exp_q.size());
    else pass_cnt++;
    check_cnt++;
    if (multi) $display("FAIL bp_multi: more than one port responded in a cycle, required at most one");
    else pass_cnt++;
    check_cnt++;
    if (req_ready !== 4'hF) $display("FAIL bp_ready_end: req_ready=%b, required 1111", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    int bad;
    for (int p = 0; p < 3; p++) set_port(p, 4'd1, 32'h40, 2'(p));
    step();
    for (int p = 0; p < 3; p++) set_port(p, 4'd0, 32'h2, 2'd0);
    step();
    clear_all();
    reset = 1'b0;
    step();
    check_cnt++;
    if (out_resp !== 8'h00 || out_data !== 128'h0 || out_tag !== 8'h00 || req_ready !== 4'hF)
      $display("FAIL midreset_state: resp=%h data=%h tag=%h ready=%b, required zeros and ready 1111",
               out_resp, out_data, out_tag, req_ready);
    else pass_cnt++;
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_resp !== 8'h00) bad++;
    end
    check_cnt++;
    if (bad != 0) $display("FAIL midreset_ghost: %0d cycles with responses, required 0", bad);
    else pass_cnt++;
    run_single(2, 4'd1, 32'h7, 32'h8, 2'd3, 2'd1, 32'hF, "post_reset_add");
  endtask

  task automatic test_param();
    logic [3:0]  er[4];
    logic [31:0] ed[4];
    apply_reset();
    p2_cmd[7:4] = 4'd1; p2_data[31:16] = 16'hFFFF; p2_tag[3:2] = 2'd2;
    step();
    p2_cmd[7:4] = 4'd0; p2_data[31:16] = 16'h0001; p2_tag[3:2] = 2'd0;
    step();
    clear_all();
    step();
    step();
    check_cnt++;
    if (p2_resp !== 4'b1000 || p2_out_data !== 32'h0 || p2_out_tag !== 4'b1000)
      $display("FAIL p2_add_carry: resp=%b data=%h tag=%b, required resp=1000 data=0 tag=1000", p2_resp, p2_out_data, p2_out_tag);
    else pass_cnt++;
    step();
    p2_cmd = 8'h11; p2_data = 32'h0010_0010; p2_tag = 4'b0101;
    step();
    p2_cmd = 8'h00; p2_data = 32'h0001_0001; p2_tag = 4'b0000;
    step();
    p2_cmd = 8'h11; p2_data = 32'h0020_0020; p2_tag = 4'b0101;
    check_cnt++;
    if (p2_ready !== 2'b11) $display("FAIL p2_ready_one: ready=%b, required 11", p2_ready);
    else pass_cnt++;
    step();
    check_cnt++;
    if (p2_ready !== 2'b01) $display("FAIL p2_ready_full: ready=%b, required 01", p2_ready);
    else pass_cnt++;
    p2_cmd = 8'h00; p2_data = 32'h0001_0001; p2_tag = 4'b0000;
    step();
    clear_all();
    er[0] = 4'b0001; ed[0] = 32'h0000_0011;
    er[1] = 4'b0100; ed[1] = 32'h0011_0000;
    er[2] = 4'b0001; ed[2] = 32'h0000_0021;
    er[3] = 4'b0100; ed[3] = 32'h0021_0000;
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (p2_resp !== er[i] || p2_out_data !== ed[i] || p2_out_tag !== er[i])
        $display("FAIL p2_resp%0d: resp=%b data=%h tag=%b, required resp=%b data=%h tag=%b",
                 i, p2_resp, p2_out_data, p2_out_tag, er[i], ed[i], er[i]);
      else pass_cnt++;
      step();
    end
    check_cnt++;
    if (p2_resp !== 4'b0000 || p2_ready !== 2'b11) $display("FAIL p2_drain: resp=%b ready=%b, required 0000 / 11", p2_resp, p2_ready);
    else pass_cnt++;
  endtask

  // Test sequence
  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_single_add();
    test_errors();
    test_back_to_back();
    test_arbitration();
    test_backpressure();
    test_reset_midop();
    test_param();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/calc_mp_engine.md
Name: calc_mp_engine

Overview:
Parametrised successor of the calc2 calculator. NUM_PORTS independent requester ports feed per-port request FIFOs. A round-robin arbiter issues one queued request per cycle to a single shared ALU (add/sub/shift). Each result returns on the originating port's response channel with the request's tag. Unlike calc2, this block adds configurable port count, data/tag width and queue depth, explicit backpressure (req_ready), and deterministic arbitration.

Parameters:
NUM_PORTS, 4, number of requester ports (1..8)
DATA_W, 32, operand/result width (power of two, >=8)
TAG_W, 2, request tag width
FIFO_DEPTH, 4, request entries per port (power of two, >=2)

Ports:
c_clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-low reset; 0 at a rising edge clears all state
req_cmd_in  in  4*NUM_PORTS  per-port command; slice p = [4p+3:4p]
req_data_in  in  DATA_W*NUM_PORTS  per-port operand
req_tag_in  in  TAG_W*NUM_PORTS  per-port tag
req_ready  out  NUM_PORTS  port p may start a request this cycle
out_resp  out  2*NUM_PORTS  per-port response: 0 none, 1 success, 2 error
out_data  out  DATA_W*NUM_PORTS  per-port result
out_tag  out  TAG_W*NUM_PORTS  per-port returned tag

Behaviour:
- Reset (reset=0 at edge): all FIFOs empty; capture FSMs to IDLE; arbiter pointer = 0; ALU stage invalid; out_resp/out_data/out_tag = 0; req_ready = all 1s on the first cycle after reset deasserts. Reset mid-operation discards every queued and in-flight request, with no responses emitted.
- Capture FSM per port, states IDLE and OP2:
  - IDLE: if cmd!=0 and req_ready[p]=1, latch cmd, tag and data as op1, then go to OP2. If cmd!=0 and req_ready[p]=0, the request is ignored (no response) and the state stays IDLE.
  - OP2: latch data as op2; cmd and tag are ignored. Write {cmd,op1,op2,tag} into the FIFO at this edge, then go to IDLE.
  - Back-to-back requests are allowed: a new op1 may come on the cycle after OP2.
- req_ready[p] = (FIFO occupancy + (state==OP2 ? 1 : 0)) < FIFO_DEPTH. This is registered-state based, so an accepted request always has a slot reserved.
- Arbiter: each cycle, grant the first non-empty FIFO at or after pointer, wrapping modulo NUM_PORTS. Pop that entry into the ALU stage. Pointer becomes grant+1 mod NUM_PORTS. With no FIFO non-empty, there is no grant and the pointer holds.
- A FIFO written and popped in the same cycle must behave correctly. A FIFO written while empty is not visible to the arbiter until the next cycle.
- ALU, registered, 1 cycle:
  - cmd 1 add: if carry out, resp 2 and data 0; else resp 1 and data op1+op2.
  - cmd 2 sub: if op2>op1 (unsigned), resp 2 and data 0; else resp 1 and data op1-op2.
  - cmd 5 shl: resp 1, data op1 << op2[log2(DATA_W)-1:0].
  - cmd 6 shr: resp 1, data op1 >> op2[log2(DATA_W)-1:0], logical.
  - Any other nonzero cmd: resp 2, data 0.
- Response: driven on the granted port's out_* for exactly one cycle. All other ports show resp 0, data 0, tag 0 that cycle. At most one port responds per cycle.
- Latency: op2 captured at edge E, FIFO pop at E+1, out_* valid during the cycle after edge E+2. Minimum is 2 cycles after the op2 cycle. Longer under contention.
- Ordering: responses per port are in request order. Across ports, order follows round-robin.
- Tags are opaque and returned unchanged; duplicate tags are legal.

Test Plan:
- Single add: after reset, port 0 sends cmd 1, tag 1, op1 0x30, then op2 0x20 -> port 0 resp 1, data 0x50, tag 1, exactly 2 cycles after the op2 cycle, one cycle wide. Other ports stay 0.
- Errors: add 0xFFFFFFFF+0x1 -> resp 2, data 0. Sub 0x5-0x6 -> resp 2. Cmd 4'h3 -> resp 2. Shl 0x1 by 0x24 (shift amount 4) -> resp 1, data 0x10. Shr 0x80000000 by 31 -> resp 1, data 0x1.
- Arbitration: all 4 ports send add requests in the same cycles (port p: op1 p, op2 1) -> responses on ports 0,1,2,3 on four consecutive cycles, data 1,2,3,4.
- Backpressure: 4 ports issue continuously for 20 cycles -> req_ready drops on some port, no FIFO overflow, every accepted request answered exactly once with the correct tag, ignored requests produce no response.
- Reset mid-operation: with 3 requests queued, hold reset=0 for one edge -> all outputs 0, no responses for pre-reset requests, req_ready all 1. A fresh add afterwards completes normally.
- Parametrised build NUM_PORTS=2, DATA_W=16, FIFO_DEPTH=2: add 0xFFFF+1 -> resp 2. Port 1 at capacity -> req_ready[1]=0.
